fft_bfly_r2: RTL and testbench

//  Pipelined radix-2 DIT butterfly for the N=8 FFT datapath, directly downstream of the twiddle ROM.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_bfly_r2_cmul.sv | 67 ++++++
 rtl/fft_bfly_r2.sv | 113 +++++++++++
 tb/tb_fft_bfly_r2.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared Q1.15 constants, complex sample type and the rounding/saturation helpers
// used by the radix-2 butterfly datapath.
package fft_pkg;

  localparam int W_DEF = 16;
  localparam int ONE   = 32767;
  localparam int SQH   = 23170;

  typedef struct packed {
    logic signed [W_DEF-1:0] re;
    logic signed [W_DEF-1:0] im;
  } cplx_t;

  // Arithmetic shift right by sh with round-half-up; sh must be >= 1.
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] x, input int sh);
    return (x + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  // Clamp x to the signed range of a w-bit value.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fft_bfly_r2_cmul.sv
// Two-stage complex multiply B * (tw_re - j*tw_im) with Q1.15 round-half-up,
// advancing both stages only when en is high.
module cmul_q15
  import fft_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_vld,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  input  logic signed [W-1:0] tw_re,
  input  logic signed [W-1:0] tw_im,
  output logic                out_vld,
  output logic signed [W:0]   t_re,
  output logic signed [W:0]   t_im
);

  logic                  vld_p0, vld_p1;
  logic signed [W-1:0]   b_re_p0, b_im_p0, tw_re_p0, tw_im_p0;
  logic signed [2*W-1:0] rr_p1, ii_p1, ir_p1, ri_p1;
  logic signed [2*W:0]   p_re, p_im;

  // S1: operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      b_re_p0  <= '0;
      b_im_p0  <= '0;
      tw_re_p0 <= '0;
      tw_im_p0 <= '0;
    end else if (en) begin
      vld_p0   <= in_vld;
      b_re_p0  <= b_re;
      b_im_p0  <= b_im;
      tw_re_p0 <= tw_re;
      tw_im_p0 <= tw_im;
    end
  end

  // S2: partial products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      rr_p1  <= '0;
      ii_p1  <= '0;
      ir_p1  <= '0;
      ri_p1  <= '0;
    end else if (en) begin
      vld_p1 <= vld_p0;
      rr_p1  <= (2*W)'(b_re_p0) * (2*W)'(tw_re_p0);
      ii_p1  <= (2*W)'(b_im_p0) * (2*W)'(tw_im_p0);
      ir_p1  <= (2*W)'(b_im_p0) * (2*W)'(tw_re_p0);
      ri_p1  <= (2*W)'(b_re_p0) * (2*W)'(tw_im_p0);
    end
  end

  // The ROM holds -Im(W), hence the sign pattern; the W+1 result wraps rather than clips.
  assign p_re    = (2*W+1)'(rr_p1) + (2*W+1)'(ii_p1);
  assign p_im    = (2*W+1)'(ir_p1) - (2*W+1)'(ri_p1);
  assign t_re    = (W+1)'(round_shr(64'(p_re), W - 1));
  assign t_im    = (W+1)'(round_shr(64'(p_im), W - 1));
  assign out_vld = vld_p1;

endmodule

// File: rtl/fft_bfly_r2.sv
// Pipelined radix-2 DIT butterfly: Y0 = A + B*W, Y1 = A - B*W, optional /2 scaling,
// saturating Q1.15 outputs and a sticky saturation flag.
module fft_bfly_r2
  import fft_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter bit SCALE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  input  logic signed [W-1:0] tw_re,
  input  logic signed [W-1:0] tw_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] y0_re,
  output logic signed [W-1:0] y0_im,
  output logic signed [W-1:0] y1_re,
  output logic signed [W-1:0] y1_im,
  output logic                sat_flag,
  input  logic                sat_clr
);

  logic                adv;
  logic                vld_p1;
  logic signed [W-1:0] a_re_p0, a_im_p0, a_re_p1, a_im_p1;
  logic signed [W:0]   t_re, t_im;
  logic signed [63:0]  s0_re, s0_im, s1_re, s1_im;
  logic                clip;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  cmul_q15 #(.W(W)) u_cmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (adv),
    .in_vld (in_valid),
    .b_re   (b_re),
    .b_im   (b_im),
    .tw_re  (tw_re),
    .tw_im  (tw_im),
    .out_vld(vld_p1),
    .t_re   (t_re),
    .t_im   (t_im)
  );

  // S1/S2: operand A delayed to line up with the product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_re_p0 <= '0;
      a_im_p0 <= '0;
      a_re_p1 <= '0;
      a_im_p1 <= '0;
    end else if (adv) begin
      a_re_p0 <= a_re;
      a_im_p0 <= a_im;
      a_re_p1 <= a_re_p0;
      a_im_p1 <= a_im_p0;
    end
  end

  always_comb begin
    s0_re = 64'(a_re_p1) + 64'(t_re);
    s0_im = 64'(a_im_p1) + 64'(t_im);
    s1_re = 64'(a_re_p1) - 64'(t_re);
    s1_im = 64'(a_im_p1) - 64'(t_im);
    if (SCALE) begin
      s0_re = round_shr(s0_re, 1);
      s0_im = round_shr(s0_im, 1);
      s1_re = round_shr(s1_re, 1);
      s1_im = round_shr(s1_im, 1);
    end
  end

  assign clip = (sat_w(s0_re, W) != s0_re) | (sat_w(s0_im, W) != s0_im) |
                (sat_w(s1_re, W) != s1_re) | (sat_w(s1_im, W) != s1_im);

  // S3: output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y0_re     <= '0;
      y0_im     <= '0;
      y1_re     <= '0;
      y1_im     <= '0;
    end else if (adv) begin
      out_valid <= vld_p1;
      y0_re     <= W'(sat_w(s0_re, W));
      y0_im     <= W'(sat_w(s0_im, W));
      y1_re     <= W'(sat_w(s1_re, W));
      y1_im     <= W'(sat_w(s1_im, W));
    end
  end

  // A clip landing in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (adv && vld_p1 && clip) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Bench for fft_bfly_r2: unscaled and scaled instances share one stimulus stream
// and are scored against an integer model of the butterfly arithmetic.
module tb_fft_bfly_r2;

  localparam int W = 16;

  typedef struct {
    int y0r, y0i, y1r, y1i;
    int z0r, z0i, z1r, z1i;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, sat_clr;
  logic signed [W-1:0] a_re, a_im, b_re, b_im, tw_re, tw_im;

  logic rdy0, ov0, sf0, rdy1, ov1, sf1;
  logic signed [W-1:0] y0r0, y0i0, y1r0, y1i0;
  logic signed [W-1:0] y0r1, y0i1, y1r1, y1i1;

  int checks = 0;
  int failures = 0;
  exp_t sbq[$];

  logic stall_prev = 1'b0;
  logic signed [W-1:0] sv_y0r, sv_y0i, sv_y1r, sv_y1i;

  always #5 clk = ~clk;

  fft_bfly_r2 #(.W(W), .SCALE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(ov0), .out_ready(out_ready),
    .y0_re(y0r0), .y0_im(y0i0), .y1_re(y1r0), .y1_im(y1i0),
    .sat_flag(sf0), .sat_clr(sat_clr)
  );

  fft_bfly_r2 #(.W(W), .SCALE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(ov1), .out_ready(out_ready),
    .y0_re(y0r1), .y0_im(y0i1), .y1_re(y1r1), .y1_im(y1i1),
    .sat_flag(sf1), .sat_clr(sat_clr)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One butterfly output component from the product p, per the Q1.15 rules.
  function automatic int bf(input int a, input longint p, input bit sub, input bit scale);
    longint t, s;
    t = (p + 16384) >>> 15;
    t = ((t % 131072) + 131072) % 131072;
    if (t >= 65536) t -= 131072;
    s = sub ? a - t : a + t;
    if (scale) s = (s + 1) >>> 1;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  function automatic exp_t model(input int ar, ai, br, bi, wr, wi);
    exp_t e;
    longint pr, pi;
    pr = longint'(br) * wr + longint'(bi) * wi;
    pi = longint'(bi) * wr - longint'(br) * wi;
    e.y0r = bf(ar, pr, 1'b0, 1'b0);
    e.y0i = bf(ai, pi, 1'b0, 1'b0);
    e.y1r = bf(ar, pr, 1'b1, 1'b0);
    e.y1i = bf(ai, pi, 1'b1, 1'b0);
    e.z0r = bf(ar, pr, 1'b0, 1'b1);
    e.z0i = bf(ai, pi, 1'b0, 1'b1);
    e.z1r = bf(ar, pr, 1'b1, 1'b1);
    e.z1i = bf(ai, pi, 1'b1, 1'b1);
    return e;
  endfunction

  function automatic int rnd_s();
    if ($urandom_range(0, 7) == 0) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      stall_prev = 1'b0;
    end else begin
      check_val("in_ready_adv", rdy0, (!ov0 || out_ready));
      check_val("in_ready_pair", rdy1, rdy0);
      check_val("out_valid_pair", ov1, ov0);
      if (stall_prev) begin
        check_val("stall_valid", ov0, 1);
        check_val("stall_y0re", y0r0, sv_y0r);
        check_val("stall_y0im", y0i0, sv_y0i);
        check_val("stall_y1re", y1r0, sv_y1r);
        check_val("stall_y1im", y1i0, sv_y1i);
      end
      if (in_valid && rdy0)
        sbq.push_back(model(int'(a_re), int'(a_im), int'(b_re), int'(b_im), int'(tw_re), int'(tw_im)));
      if (ov0 && out_ready) begin
        if (sbq.size() == 0) begin
          check_val("unexpected_beat", 1, 0);
        end else begin
          e = sbq.pop_front();
          check_val("sb_y0re", y0r0, e.y0r);
          check_val("sb_y0im", y0i0, e.y0i);
          check_val("sb_y1re", y1r0, e.y1r);
          check_val("sb_y1im", y1i0, e.y1i);
          check_val("sb_scaled_y0re", y0r1, e.z0r);
          check_val("sb_scaled_y0im", y0i1, e.z0i);
          check_val("sb_scaled_y1re", y1r1, e.z1r);
          check_val("sb_scaled_y1im", y1i1, e.z1i);
        end
      end
      stall_prev = ov0 && !out_ready;
      sv_y0r = y0r0;
      sv_y0i = y0i0;
      sv_y1r = y1r0;
      sv_y1i = y1i0;
    end
  end

  task automatic set_inputs(input int ar, ai, br, bi, wr, wi);
    a_re  = 16'(ar);
    a_im  = 16'(ai);
    b_re  = 16'(br);
    b_im  = 16'(bi);
    tw_re = 16'(wr);
    tw_im = 16'(wi);
  endtask

  // Present one beat and return #1 after the edge that accepts it.
  task automatic send_beat(input int ar, ai, br, bi, wr, wi);
    bit ok;
    set_inputs(ar, ai, br, bi, wr, wi);
    in_valid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      ok = rdy0;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    check_val("send_timeout", 0, 1);
  endtask

  // Single beat into an empty pipe; returns in the cycle out_valid should rise.
  task automatic drive_and_wait(input string tag, input int ar, ai, br, bi, wr, wi, input bit clr);
    send_beat(ar, ai, br, bi, wr, wi);
    in_valid = 1'b0;
    check_val({tag, "_lat1"}, ov0, 0);
    @(posedge clk);
    #1;
    check_val({tag, "_lat2"}, ov0, 0);
    sat_clr = clr;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check_val({tag, "_lat3"}, ov0, 1);
  endtask

  task automatic pulse_clr();
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, stale;
    bit pend, hs;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sat_clr = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", ov0, 0);
    check_val("rst_sat_flag", sf0, 0);
    check_val("rst_y0re", y0r0, 0);
    check_val("rst_y1im_scaled", y1i1, 0);
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready", rdy0, 1);
    @(posedge clk);
    #1;

    drive_and_wait("ident", 1000, 0, 1000, 0, 32767, 0, 1'b0);
    check_val("ident_y0re", y0r0, 2000);
    check_val("ident_y0im", y0i0, 0);
    check_val("ident_y1re", y1r0, 0);
    check_val("ident_y1im", y1i0, 0);
    check_val("ident_scaled_y0re", y0r1, 1000);
    check_val("ident_scaled_y1re", y1r1, 0);
    @(posedge clk);
    #1;

    drive_and_wait("negj", 0, 0, 1000, 0, 0, 32767, 1'b0);
    check_val("negj_y0re", y0r0, 0);
    check_val("negj_y0im", y0i0, -1000);
    check_val("negj_y1re", y1r0, 0);
    check_val("negj_y1im", y1i0, 1000);
    check_val("negj_scaled_y0im", y0i1, -500);
    check_val("negj_scaled_y1im", y1i1, 500);
    @(posedge clk);
    #1;

    drive_and_wait("sat", 32767, 0, 32767, 0, 32767, 0, 1'b0);
    check_val("sat_y0re", y0r0, 32767);
    check_val("sat_y1re", y1r0, 1);
    check_val("sat_scaled_y0re", y0r1, 32767);
    check_val("sat_scaled_y1re", y1r1, 1);
    check_val("sat_flag_set", sf0, 1);
    check_val("sat_flag_scaled_clear", sf1, 0);
    pulse_clr();
    check_val("sat_flag_cleared", sf0, 0);

    drive_and_wait("setwins", 32767, 0, 32767, 0, 32767, 0, 1'b1);
    check_val("setwins_flag", sf0, 1);
    @(posedge clk);
    #1;
    pulse_clr();
    check_val("setwins_cleared", sf0, 0);

    drive_and_wait("tw8000", 0, 0, -32768, 0, -32768, 0, 1'b0);
    check_val("tw8000_y0re", y0r0, 32767);
    check_val("tw8000_y1re", y1r0, -32768);
    check_val("tw8000_scaled_y0re", y0r1, 16384);
    check_val("tw8000_scaled_y1re", y1r1, -16384);
    check_val("tw8000_flag", sf0, 1);
    @(posedge clk);
    #1;
    pulse_clr();

    // Random stream with random backpressure and input gaps.
    sent = 0;
    pend = 1'b0;
    for (int cyc = 0; cyc < 4000 && (sent < 40 || sbq.size() != 0); cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!pend && sent < 40 && $urandom_range(0, 3) != 0) begin
        set_inputs(rnd_s(), rnd_s(), rnd_s(), rnd_s(), rnd_s(), rnd_s());
        in_valid = 1'b1;
        pend = 1'b1;
      end
      @(negedge clk);
      hs = in_valid && rdy0;
      @(posedge clk);
      #1;
      if (hs) begin
        pend = 1'b0;
        sent++;
        in_valid = 1'b0;
      end
    end
    check_val("bp_sent", sent, 40);
    check_val("bp_drained", sbq.size(), 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three saturating beats in flight.
    for (int k = 0; k < 3; k++) send_beat(32767, 0, 32767, 0, 32767, 0);
    in_valid = 1'b0;
    check_val("pre_rst_flag", sf0, 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", ov0, 0);
    check_val("midrst_out_valid_scaled", ov1, 0);
    check_val("midrst_sat_flag", sf0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov0 || ov1) stale++;
    end
    check_val("no_stale_beats", stale, 0);
    @(posedge clk);
    #1;

    drive_and_wait("post_rst", 1000, 0, 1000, 0, 32767, 0, 1'b0);
    check_val("post_rst_y0re", y0r0, 2000);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
